pool_scheduler: RTL and testbench
=================================

Name: pool_scheduler

Overview:
- Sequences the shapool hasher pool for one job at a time.
- Accepts a "job loaded" handshake from external_io and holds the pool in reset while the configuration settles.
- Releases the pool, tracks nonce-space progress and captures the first successful nonce.
- Reports found, exhausted or idle status to the host-facing logic (ready_n, status LED, result register).

Parameters:
POOL_SIZE_LOG2, 1, log2 of hasher units; nonce is split as {unit index, per-unit nonce}.
NONCE_WIDTH, 31, per-unit nonce width (32 - POOL_SIZE_LOG2).
ROUND_CYCLES, 67, clock cycles per hash attempt per unit; must be >= 2.
ARM_CYCLES, 4, cycles the pool is held in reset after a job is accepted; must be >= 1.
ATTEMPT_WIDTH, 31, attempt counter width; exhaustion occurs after 2^ATTEMPT_WIDTH attempts (benches override to a small value).

Ports:
clk  in  1  system clock (PLL global clock)
reset_n  in  1  asynchronous active-low reset
job_valid_in  in  1  new job configuration is stable in external_io
job_ready_out  out  1  scheduler can accept a job; a job is accepted in any cycle where job_valid_in & job_ready_out
pool_reset_n_out  out  1  active-low reset to shapool
pool_success_in  in  1  shapool success flag
pool_nonce_in  in  NONCE_WIDTH  shapool nonce, valid when pool_success_in = 1
result_valid_out  out  1  result_nonce_out holds a captured winning nonce
result_nonce_out  out  32  {POOL_SIZE_LOG2 zeros, captured nonce}
result_ack_in  in  1  host has read the result (single-cycle pulse)
ready_out  out  1  registered found flag; drives the ready_n open-drain pad
busy_out  out  1  state is ARM or RUN
exhausted_out  out  1  nonce space was covered with no success

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Reset values:
  - state = IDLE
  - pool_reset_n_out = 0
  - result_valid_out = 0, result_nonce_out = 0
  - ready_out = 0, busy_out = 0, exhausted_out = 0
  - all counters = 0
- All outputs are registered, except job_ready_out = (state != ARM).
- States:
  - IDLE: pool held in reset. On accept: go to ARM, load arm_cnt = ARM_CYCLES-1.
  - ARM: pool_reset_n_out = 0. Decrement arm_cnt; when arm_cnt == 0, go to RUN and clear round_cnt and attempt_cnt. pool_success_in is ignored. job_valid_in is not accepted (job_ready_out = 0).
  - RUN: pool_reset_n_out = 1.
    - round_cnt counts 0..ROUND_CYCLES-1 and wraps.
    - On each round wrap, attempt_cnt increments.
    - pool_success_in = 1: capture pool_nonce_in, go to FOUND.
    - No success, round wrap, and attempt_cnt all-ones: go to EXHAUSTED.
  - FOUND: pool_reset_n_out = 0 (freezes the pool). result_valid_out = 1 and ready_out = 1, both asserted the cycle after capture. On result_ack_in: go to IDLE and clear result_valid_out and ready_out; result_nonce_out retains its value.
  - EXHAUSTED: pool_reset_n_out = 0. exhausted_out = 1 until the next accept.
- Preemption: an accept in RUN, FOUND or EXHAUSTED goes to ARM. It clears result_valid_out, ready_out and exhausted_out, and reloads arm_cnt.
- Priority when events coincide: accept > success > exhaustion. A success and an exhaustion in the same cycle resolve to FOUND.
- result_ack_in outside FOUND is ignored.
- Latency:
  - Accept to pool release: ARM_CYCLES+1 cycles.
  - Success to result_valid_out: 1 cycle.
- Asynchronous reset mid-run returns to IDLE with the pool in reset; no result is retained.
- Counter widths: round_cnt is $clog2(ROUND_CYCLES); attempt_cnt is ATTEMPT_WIDTH, wrap-free (the exhaustion check precedes the increment).

Decomposition:
- Shared package (shapool_pkg): state encoding (IDLE, ARM, RUN, FOUND, EXHAUSTED, 3 bits), NONCE_TOTAL_WIDTH = 32, default ROUND_CYCLES.
- One natural sub-module: progress_counter (round_cnt plus attempt_cnt, with wrap and last pulses).
- The FSM and result register stay in pool_scheduler.

Test Plan:
- Reset, then job_valid_in pulse with ARM_CYCLES = 4 -> job_ready_out drops, pool_reset_n_out rises exactly 5 cycles after the accept, busy_out = 1.
- RUN, pool_success_in = 1 with pool_nonce_in = 0x1234_5678 (NONCE_WIDTH = 31) -> next cycle result_valid_out = 1, ready_out = 1, result_nonce_out = 0x1234_5678, pool_reset_n_out = 0; result_ack_in -> IDLE, ready_out = 0.
- ATTEMPT_WIDTH = 3, ROUND_CYCLES = 4, no success -> exhausted_out = 1 after exactly 32 RUN cycles, pool held in reset.
- Success and exhaustion in the same cycle -> FOUND, exhausted_out stays 0.
- job_valid_in in FOUND with an unacked result -> result_valid_out = 0, state ARM, new run starts; job_valid_in during ARM -> not accepted.
- reset_n asserted mid-RUN -> all outputs return to reset values asynchronously; after release, IDLE with job_ready_out = 1.

Source files
------------

// File: rtl/shapool_pkg.sv
// Shared definitions for the shapool hasher pool sequencing logic.
package shapool_pkg;

    localparam int unsigned NONCE_TOTAL_WIDTH    = 32;
    localparam int unsigned DEFAULT_ROUND_CYCLES = 67;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_RUN       = 3'd2,
        ST_FOUND     = 3'd3,
        ST_EXHAUSTED = 3'd4
    } state_e;

endpackage

// File: rtl/progress_counter.sv
// Nonce-space progress tracking: cycles within a hash round plus completed attempts.
module progress_counter #(
    parameter int unsigned ROUND_CYCLES  = 67,
    parameter int unsigned ATTEMPT_WIDTH = 31
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_in,
    input  logic en_in,
    output logic round_wrap_c,
    output logic attempt_last_c
);

    localparam int unsigned ROUND_W = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUND_CYCLES - 1);

    logic [ROUND_W-1:0]       round_cnt_q;
    logic [ROUND_W-1:0]       round_cnt_d;
    logic [ATTEMPT_WIDTH-1:0] attempt_cnt_q;
    logic [ATTEMPT_WIDTH-1:0] attempt_cnt_d;

    // The attempt counter saturates at all-ones; the scheduler leaves RUN on that wrap.
    always_comb begin
        round_wrap_c   = en_in && (round_cnt_q == ROUND_LAST);
        attempt_last_c = &attempt_cnt_q;
        round_cnt_d    = round_cnt_q;
        attempt_cnt_d  = attempt_cnt_q;
        if (clear_in) begin
            round_cnt_d   = '0;
            attempt_cnt_d = '0;
        end else if (en_in) begin
            round_cnt_d = round_wrap_c ? '0 : round_cnt_q + ROUND_W'(1);
            if (round_wrap_c && !attempt_last_c) begin
                attempt_cnt_d = attempt_cnt_q + ATTEMPT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            round_cnt_q   <= '0;
            attempt_cnt_q <= '0;
        end else begin
            round_cnt_q   <= round_cnt_d;
            attempt_cnt_q <= attempt_cnt_d;
        end
    end

endmodule

// File: rtl/pool_scheduler.sv
// Sequences the shapool hasher pool for one job: arm, run, capture the winning nonce or report exhaustion.
module pool_scheduler
    import shapool_pkg::*;
#(
    parameter int unsigned POOL_SIZE_LOG2 = 1,
    parameter int unsigned NONCE_WIDTH    = NONCE_TOTAL_WIDTH - POOL_SIZE_LOG2,
    parameter int unsigned ROUND_CYCLES   = DEFAULT_ROUND_CYCLES,
    parameter int unsigned ARM_CYCLES     = 4,
    parameter int unsigned ATTEMPT_WIDTH  = 31
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         job_valid_in,
    output logic                         job_ready_out,
    output logic                         pool_reset_n_out,
    input  logic                         pool_success_in,
    input  logic [NONCE_WIDTH-1:0]       pool_nonce_in,
    output logic                         result_valid_out,
    output logic [NONCE_TOTAL_WIDTH-1:0] result_nonce_out,
    input  logic                         result_ack_in,
    output logic                         ready_out,
    output logic                         busy_out,
    output logic                         exhausted_out
);

    localparam int unsigned ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(ARM_CYCLES - 1);

    state_e                         state_q;
    state_e                         state_d;
    logic [ARM_W-1:0]               arm_cnt_q;
    logic [ARM_W-1:0]               arm_cnt_d;
    logic                           pool_reset_n_q;
    logic                           pool_reset_n_d;
    logic                           result_valid_q;
    logic                           result_valid_d;
    logic [NONCE_TOTAL_WIDTH-1:0]   result_nonce_q;
    logic [NONCE_TOTAL_WIDTH-1:0]   result_nonce_d;
    logic                           ready_q;
    logic                           ready_d;
    logic                           busy_q;
    logic                           busy_d;
    logic                           exhausted_q;
    logic                           exhausted_d;

    logic accept_c;
    logic round_wrap_c;
    logic attempt_last_c;

    progress_counter #(
        .ROUND_CYCLES  (ROUND_CYCLES),
        .ATTEMPT_WIDTH (ATTEMPT_WIDTH)
    ) u_progress (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear_in       (state_q == ST_ARM),
        .en_in          (state_q == ST_RUN),
        .round_wrap_c   (round_wrap_c),
        .attempt_last_c (attempt_last_c)
    );

    assign job_ready_out = (state_q != ST_ARM);
    assign accept_c      = job_valid_in && job_ready_out;

    // Next state; an accept preempts every other event, success outranks exhaustion.
    always_comb begin
        state_d        = state_q;
        arm_cnt_d      = arm_cnt_q;
        result_valid_d = result_valid_q;
        result_nonce_d = result_nonce_q;
        ready_d        = ready_q;
        exhausted_d    = exhausted_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (arm_cnt_q == '0) state_d   = ST_RUN;
                else                 arm_cnt_d = arm_cnt_q - ARM_W'(1);
            end
            ST_RUN: begin
                if (accept_c) begin
                    state_d = ST_ARM;
                end else if (pool_success_in) begin
                    state_d        = ST_FOUND;
                    result_valid_d = 1'b1;
                    ready_d        = 1'b1;
                    result_nonce_d = NONCE_TOTAL_WIDTH'(pool_nonce_in);
                end else if (round_wrap_c && attempt_last_c) begin
                    state_d     = ST_EXHAUSTED;
                    exhausted_d = 1'b1;
                end
            end
            ST_FOUND: begin
                if (accept_c) begin
                    state_d = ST_ARM;
                end else if (result_ack_in) begin
                    state_d        = ST_IDLE;
                    result_valid_d = 1'b0;
                    ready_d        = 1'b0;
                end
            end
            ST_EXHAUSTED: begin
                if (accept_c) state_d = ST_ARM;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept_c) begin
            arm_cnt_d      = ARM_LOAD;
            result_valid_d = 1'b0;
            ready_d        = 1'b0;
            exhausted_d    = 1'b0;
        end

        // Pool only runs in RUN; registering from state_d keeps the release aligned with the state.
        pool_reset_n_d = (state_d == ST_RUN);
        busy_d         = (state_d == ST_ARM) || (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            arm_cnt_q      <= '0;
            pool_reset_n_q <= 1'b0;
            result_valid_q <= 1'b0;
            result_nonce_q <= '0;
            ready_q        <= 1'b0;
            busy_q         <= 1'b0;
            exhausted_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            arm_cnt_q      <= arm_cnt_d;
            pool_reset_n_q <= pool_reset_n_d;
            result_valid_q <= result_valid_d;
            result_nonce_q <= result_nonce_d;
            ready_q        <= ready_d;
            busy_q         <= busy_d;
            exhausted_q    <= exhausted_d;
        end
    end

    assign pool_reset_n_out = pool_reset_n_q;
    assign result_valid_out = result_valid_q;
    assign result_nonce_out = result_nonce_q;
    assign ready_out        = ready_q;
    assign busy_out         = busy_q;
    assign exhausted_out    = exhausted_q;

endmodule

// File: tb/tb_pool_scheduler.sv
// Scoreboard bench for pool_scheduler: directed jobs with hand-computed results and latencies.
module tb_pool_scheduler;

    localparam int unsigned ARM_C   = 4;
    localparam int unsigned ROUND_C = 4;
    localparam int unsigned ATT_W   = 3;
    localparam int unsigned RUN_TO_EXHAUST = 32;

    typedef struct packed {
        logic        is_found;
        logic [31:0] nonce;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        job_valid_in;
    logic        job_ready_out;
    logic        pool_reset_n_out;
    logic        pool_success_in;
    logic [30:0] pool_nonce_in;
    logic        result_valid_out;
    logic [31:0] result_nonce_out;
    logic        result_ack_in;
    logic        ready_out;
    logic        busy_out;
    logic        exhausted_out;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    pool_scheduler #(
        .POOL_SIZE_LOG2 (1),
        .NONCE_WIDTH    (31),
        .ROUND_CYCLES   (ROUND_C),
        .ARM_CYCLES     (ARM_C),
        .ATTEMPT_WIDTH  (ATT_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .job_valid_in     (job_valid_in),
        .job_ready_out    (job_ready_out),
        .pool_reset_n_out (pool_reset_n_out),
        .pool_success_in  (pool_success_in),
        .pool_nonce_in    (pool_nonce_in),
        .result_valid_out (result_valid_out),
        .result_nonce_out (result_nonce_out),
        .result_ack_in    (result_ack_in),
        .ready_out        (ready_out),
        .busy_out         (busy_out),
        .exhausted_out    (exhausted_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rising result_valid/exhausted must match the oldest expected outcome.
    initial begin : monitor
        logic prev_rv;
        logic prev_ex;
        exp_t e;
        prev_rv = 1'b0;
        prev_ex = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (result_valid_out && !prev_rv) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_found: got nonce 0x%08h required no result", result_nonce_out);
                    end else begin
                        e = sb_q.pop_front();
                        chk1("sb_kind_found", 1'b1, e.is_found);
                        chk32("sb_nonce", result_nonce_out, e.nonce);
                        chk1("sb_found_pool_frozen", pool_reset_n_out, 1'b0);
                        chk1("sb_found_no_exhaust", exhausted_out, 1'b0);
                    end
                end
                if (exhausted_out && !prev_ex) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_exhaust: got exhausted=1 required no event");
                    end else begin
                        e = sb_q.pop_front();
                        chk1("sb_kind_exhaust", 1'b0, e.is_found);
                        chk1("sb_exh_pool_frozen", pool_reset_n_out, 1'b0);
                        chk1("sb_exh_no_result", result_valid_out, 1'b0);
                    end
                end
            end
            prev_rv = result_valid_out;
            prev_ex = exhausted_out;
        end
    end

    // Called at a negedge; returns at the negedge where the pool has just been released.
    task automatic start_job(input bit hold_valid, input bit success_in_arm);
        job_valid_in = 1'b1;
        if (success_in_arm) begin
            pool_success_in = 1'b1;
            pool_nonce_in   = 31'h0555_AAAA;
        end
        @(negedge clk);
        if (!hold_valid) job_valid_in = 1'b0;
        chk1("arm_busy", busy_out, 1'b1);
        chk1("arm_job_ready", job_ready_out, 1'b0);
        chk1("arm_result_cleared", result_valid_out, 1'b0);
        chk1("arm_ready_cleared", ready_out, 1'b0);
        chk1("arm_exhaust_cleared", exhausted_out, 1'b0);
        for (int i = 1; i <= int'(ARM_C); i++) begin
            chk1("arm_pool_held", pool_reset_n_out, 1'b0);
            @(negedge clk);
            if (i == int'(ARM_C) - 1) begin
                job_valid_in    = 1'b0;
                pool_success_in = 1'b0;
            end
        end
        chk1("release_latency", pool_reset_n_out, 1'b1);
        chk1("run_busy", busy_out, 1'b1);
        chk1("run_job_ready", job_ready_out, 1'b1);
    endtask

    task automatic ack_result();
        result_ack_in = 1'b1;
        @(negedge clk);
        result_ack_in = 1'b0;
        chk1("ack_valid_clear", result_valid_out, 1'b0);
        chk1("ack_ready_clear", ready_out, 1'b0);
        chk1("ack_idle_job_ready", job_ready_out, 1'b1);
    endtask

    initial begin : stimulus
        exp_t x;
        reset_n         = 1'b0;
        job_valid_in    = 1'b0;
        pool_success_in = 1'b0;
        pool_nonce_in   = '0;
        result_ack_in   = 1'b0;

        #12;
        chk1("rst_pool_reset_n", pool_reset_n_out, 1'b0);
        chk1("rst_result_valid", result_valid_out, 1'b0);
        chk32("rst_result_nonce", result_nonce_out, 32'h0);
        chk1("rst_ready", ready_out, 1'b0);
        chk1("rst_busy", busy_out, 1'b0);
        chk1("rst_exhausted", exhausted_out, 1'b0);
        chk1("rst_job_ready", job_ready_out, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk1("idle_pool_held", pool_reset_n_out, 1'b0);

        // Job 1: success two cycles into RUN, then host ack.
        start_job(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        pool_success_in = 1'b1;
        pool_nonce_in   = 31'h1234_5678;
        x = '{is_found: 1'b1, nonce: 32'h1234_5678};
        sb_q.push_back(x);
        @(negedge clk);
        pool_success_in = 1'b0;
        chk1("found_valid", result_valid_out, 1'b1);
        chk1("found_ready", ready_out, 1'b1);
        chk32("found_nonce", result_nonce_out, 32'h1234_5678);
        chk1("found_pool_frozen", pool_reset_n_out, 1'b0);
        chk1("found_busy", busy_out, 1'b0);
        repeat (2) @(negedge clk);
        chk1("found_hold_valid", result_valid_out, 1'b1);
        ack_result();
        chk32("ack_nonce_kept", result_nonce_out, 32'h1234_5678);

        // Job 2: job_valid held through ARM (not re-accepted), no success -> exhaustion.
        start_job(1'b1, 1'b0);
        x = '{is_found: 1'b0, nonce: 32'h0};
        sb_q.push_back(x);
        for (int n = 1; n <= int'(RUN_TO_EXHAUST); n++) begin
            @(negedge clk);
            if (n == int'(RUN_TO_EXHAUST) - 1) begin
                chk1("pre_exhaust_running", pool_reset_n_out, 1'b1);
                chk1("pre_exhaust_flag", exhausted_out, 1'b0);
            end
        end
        chk1("exhaust_flag", exhausted_out, 1'b1);
        chk1("exhaust_pool_held", pool_reset_n_out, 1'b0);
        chk1("exhaust_busy", busy_out, 1'b0);
        result_ack_in = 1'b1;
        @(negedge clk);
        result_ack_in = 1'b0;
        repeat (2) @(negedge clk);
        chk1("exhaust_ack_ignored", exhausted_out, 1'b1);

        // Job 3: preempt EXHAUSTED; success coincides with the exhausting wrap.
        start_job(1'b0, 1'b0);
        repeat (int'(RUN_TO_EXHAUST) - 1) @(negedge clk);
        pool_success_in = 1'b1;
        pool_nonce_in   = 31'h7ABC_DEF0;
        x = '{is_found: 1'b1, nonce: 32'h7ABC_DEF0};
        sb_q.push_back(x);
        @(negedge clk);
        pool_success_in = 1'b0;
        chk1("tie_found", result_valid_out, 1'b1);
        chk1("tie_no_exhaust", exhausted_out, 1'b0);
        chk32("tie_nonce", result_nonce_out, 32'h7ABC_DEF0);
        @(negedge clk);
        chk1("tie_no_exhaust_later", exhausted_out, 1'b0);

        // Job 4: preempt FOUND with unacked result; success during ARM is ignored.
        start_job(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk1("arm_success_ignored", result_valid_out, 1'b0);
        pool_success_in = 1'b1;
        pool_nonce_in   = 31'h7FFF_FFFF;
        x = '{is_found: 1'b1, nonce: 32'h7FFF_FFFF};
        sb_q.push_back(x);
        @(negedge clk);
        pool_success_in = 1'b0;
        chk32("max_nonce", result_nonce_out, 32'h7FFF_FFFF);
        ack_result();

        // Job 5: asynchronous reset in the middle of RUN.
        start_job(1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk1("mid_rst_pool", pool_reset_n_out, 1'b0);
        chk1("mid_rst_busy", busy_out, 1'b0);
        chk1("mid_rst_valid", result_valid_out, 1'b0);
        chk32("mid_rst_nonce", result_nonce_out, 32'h0);
        chk1("mid_rst_ready", ready_out, 1'b0);
        chk1("mid_rst_exhaust", exhausted_out, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk1("post_rst_job_ready", job_ready_out, 1'b1);
        chk1("post_rst_busy", busy_out, 1'b0);
        chk1("post_rst_pool", pool_reset_n_out, 1'b0);

        repeat (2) @(negedge clk);
        chk32("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
